// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - shared types for the pipeline step sequencer
//
// Purpose: debug command codes, sequencer state encoding and small
//          state-decode helpers used by pipeline_step_ctrl.
// Ports:   none (package).

package step_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_RUN_N = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_RUNN   = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // States in which the PC and every pipeline latch advance.
    function automatic logic is_stepping(state_t s);
        return (s == ST_RUN) || (s == ST_RUNN) || (s == ST_STEP);
    endfunction

    // Free-running modes, as opposed to a single step.
    function automatic logic is_running(state_t s);
        return (s == ST_RUN) || (s == ST_RUNN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Purpose: counts enabled clock edges and holds at all-ones instead of
//          wrapping.
// Ports:
//   clk  in  1  clock
//   rst  in  1  asynchronous active-high reset, clears q
//   en   in  1  count this edge
//   clr  in  1  synchronous clear, takes priority over en
//   q    out W  current count

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// rtl/pipeline_step_ctrl.sv - step-enable sequencer for PC and pipeline latches
//
// Purpose: turns debug-unit RUN / STEP / RUN_N / stop commands into the one
//          o_step enable shared by the PC and all pipeline latches, freezes
//          on a HALT at write-back and counts executed pipeline cycles.
// Ports:
//   clk            in  1      clock
//   rst            in  1      asynchronous active-high reset
//   i_cmd_valid    in  1      command strobe
//   i_cmd          in  2      0 NOP, 1 RUN, 2 STEP, 3 RUN_N
//   i_cmd_stop     in  1      stop request (not qualified by i_cmd_valid)
//   i_cmd_arg      in  CNT_W  cycle budget for RUN_N
//   o_cmd_ready    out 1      command accepted when valid && ready
//   i_halt_wb      in  1      HALT flag at the MEM/WB latch output
//   o_step         out 1      enable to PC and all latches
//   o_running      out 1      in RUN or RUN_N
//   o_halted       out 1      sticky halt
//   o_cycle_count  out CNT_W  saturating count of o_step cycles

module pipeline_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    input  logic             i_cmd_stop,
    input  logic [CNT_W-1:0] i_cmd_arg,
    output logic             o_cmd_ready,
    input  logic             i_halt_wb,
    output logic             o_step,
    output logic             o_running,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;

    assign o_cmd_ready = (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    case (cmd_t'(i_cmd))
                        CMD_RUN:  state_nxt = ST_RUN;
                        CMD_STEP: state_nxt = ST_STEP;
                        CMD_RUN_N: begin
                            // A zero budget is consumed without stepping.
                            // Otherwise rem counts the cycles still owed
                            // after the first one.
                            if (i_cmd_arg != '0) begin
                                state_nxt = ST_RUNN;
                                rem_nxt   = i_cmd_arg - ONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (i_halt_wb) begin
                    state_nxt = ST_HALTED;
                end else if (i_cmd_stop) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUNN: begin
                if (i_halt_wb) begin
                    state_nxt = ST_HALTED;
                end else if (i_cmd_stop || (rem == '0)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rem_nxt = rem - ONE;
                end
            end
            ST_STEP: begin
                state_nxt = i_halt_wb ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and are cleared by the asynchronous reset at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rem       <= '0;
            o_step    <= 1'b0;
            o_running <= 1'b0;
            o_halted  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            o_step    <= is_stepping(state_nxt);
            o_running <= is_running(state_nxt);
            o_halted  <= (state_nxt == ST_HALTED);
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (o_step),
        .clr (1'b0),
        .q   (o_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// tb/tb_pipeline_step_ctrl.sv - self-checking bench for pipeline_step_ctrl

module tb_pipeline_step_ctrl;
    import step_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic        cmd_stop = 1'b0;
    logic [31:0] cmd_arg = '0;
    logic        cmd_ready;
    logic        halt_wb = 1'b0;
    logic        step, running, halted;
    logic [31:0] cycle_count;

    logic        rst4 = 1'b1;
    logic        cmd_valid4 = 1'b0;
    logic [1:0]  cmd4 = 2'd0;
    logic [3:0]  cmd_arg4 = '0;
    logic        cmd_ready4, step4, running4, halted4;
    logic [3:0]  cycle_count4;

    always #5 clk = ~clk;

    pipeline_step_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_cmd_stop(cmd_stop), .i_cmd_arg(cmd_arg), .o_cmd_ready(cmd_ready),
        .i_halt_wb(halt_wb), .o_step(step), .o_running(running),
        .o_halted(halted), .o_cycle_count(cycle_count)
    );

    pipeline_step_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .i_cmd_valid(cmd_valid4), .i_cmd(cmd4),
        .i_cmd_stop(1'b0), .i_cmd_arg(cmd_arg4), .o_cmd_ready(cmd_ready4),
        .i_halt_wb(1'b0), .o_step(step4), .o_running(running4),
        .o_halted(halted4), .o_cycle_count(cycle_count4)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: 0 idle, 1 run, 2 run_n, 3 step, 4 halted.
    int          m_mode = 0;
    longint      m_rem  = 0;
    longint      m_cnt  = 0;

    typedef struct {
        bit     step;
        bit     run;
        bit     halt;
        bit     ready;
        longint cnt;
    } exp_t;

    exp_t exp_q[$];
    int   steps_seen;
    int   cyc_no = 0;

    task automatic model_advance(bit v, logic [1:0] c, bit stp, bit hlt, longint arg);
        if (m_mode inside {1, 2, 3} && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_mode == 0) begin
            if (v && c == CMD_RUN) m_mode = 1;
            else if (v && c == CMD_STEP) m_mode = 3;
            else if (v && c == CMD_RUN_N && arg > 0) begin
                m_mode = 2;
                m_rem  = arg - 1;
            end
        end else if (m_mode == 3) begin
            m_mode = hlt ? 4 : 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (hlt) m_mode = 4;
            else if (stp) m_mode = 0;
            else if (m_mode == 2 && m_rem == 0) m_mode = 0;
            else if (m_mode == 2) m_rem--;
        end
    endtask

    task automatic drive_cycle(bit v, logic [1:0] c, bit stp, bit hlt, longint arg);
        exp_t e, got;
        cmd_valid = v;
        cmd       = c;
        cmd_stop  = stp;
        halt_wb   = hlt;
        cmd_arg   = arg[31:0];
        model_advance(v, c, stp, hlt, arg);
        e.step  = m_mode inside {1, 2, 3};
        e.run   = m_mode inside {1, 2};
        e.halt  = (m_mode == 4);
        e.ready = (m_mode == 0);
        e.cnt   = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        got = exp_q.pop_front();
        check($sformatf("cyc%0d_flags{step,run,halt,ready}", cyc_no),
              {step, running, halted, cmd_ready},
              {got.step, got.run, got.halt, got.ready});
        check($sformatf("cyc%0d_count", cyc_no), cycle_count, got.cnt);
        steps_seen += int'(step);
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) drive_cycle(0, CMD_NOP, 0, 0, 0);
    endtask

    typedef struct {
        logic [1:0] cmd;
        longint     arg;
        int         len;
        int         stop_at;
        int         exp_steps;
    } scen_t;

    scen_t  scen[8];
    longint exp_total;

    initial begin
        scen[0] = '{CMD_STEP,  0,  4, -1,  1};
        scen[1] = '{CMD_RUN_N, 5,  8, -1,  5};
        scen[2] = '{CMD_RUN_N, 0,  4, -1,  0};
        scen[3] = '{CMD_RUN_N, 3,  6,  2,  2};
        scen[4] = '{CMD_RUN_N, 1,  4, -1,  1};
        scen[5] = '{CMD_RUN,   0, 13, 10, 10};
        scen[6] = '{CMD_NOP,   0,  3, -1,  0};
        scen[7] = '{CMD_RUN_N, 4,  6,  4,  4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_step", step, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_count", cycle_count, 0);
        check("rst_ready", cmd_ready, 1);
        rst  = 1'b0;
        rst4 = 1'b0;

        // Reset pulse in the middle of RUN: outputs drop without a clock edge
        drive_cycle(1, CMD_RUN, 0, 0, 0);
        idle_cycles(4);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_step", step, 0);
        check("midrun_rst_running", running, 0);
        check("midrun_rst_halted", halted, 0);
        check("midrun_rst_count", cycle_count, 0);
        check("midrun_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_mode = 0;
        m_rem  = 0;
        m_cnt  = 0;
        idle_cycles(3);

        // Table-driven command scenarios
        exp_total = 0;
        for (int s = 0; s < 8; s++) begin
            steps_seen = 0;
            drive_cycle(1, scen[s].cmd, scen[s].stop_at == 0, 0, scen[s].arg);
            for (int i = 1; i < scen[s].len; i++)
                drive_cycle(0, CMD_NOP, i == scen[s].stop_at, 0, 0);
            exp_total += scen[s].exp_steps;
            check($sformatf("scen%0d_steps", s), steps_seen, scen[s].exp_steps);
            check($sformatf("scen%0d_total_count", s), cycle_count, exp_total);
        end

        // STEP x3, one command every 2 cycles
        steps_seen = 0;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, CMD_STEP, 0, 0, 0);
            drive_cycle(0, CMD_NOP, 0, 0, 0);
        end
        exp_total += 3;
        check("step3_pulses", steps_seen, 3);
        check("step3_count", cycle_count, exp_total);

        // STEP held every cycle: the one issued while stepping is not accepted
        steps_seen = 0;
        for (int k = 0; k < 3; k++) drive_cycle(1, CMD_STEP, 0, 0, 0);
        idle_cycles(2);
        exp_total += 2;
        check("step_b2b_pulses", steps_seen, 2);
        check("step_b2b_count", cycle_count, exp_total);

        // RUN, halt and stop together at cycle 7: halt wins
        steps_seen = 0;
        drive_cycle(1, CMD_RUN, 0, 0, 0);
        for (int i = 1; i < 10; i++) drive_cycle(0, CMD_NOP, i == 7, i == 7, 0);
        exp_total += 7;
        check("halt_steps", steps_seen, 7);
        check("halt_flag", halted, 1);
        check("halt_count", cycle_count, exp_total);

        // Commands and stop are ignored once halted
        steps_seen = 0;
        drive_cycle(1, CMD_RUN, 0, 0, 0);
        drive_cycle(1, CMD_STEP, 1, 0, 0);
        drive_cycle(1, CMD_RUN_N, 0, 0, 5);
        idle_cycles(3);
        check("halted_no_steps", steps_seen, 0);
        check("halted_ready", cmd_ready, 0);
        check("halted_count_hold", cycle_count, exp_total);

        // Narrow counter saturates at 15
        cmd_valid4 = 1'b1;
        cmd4       = CMD_RUN;
        @(posedge clk);
        #1;
        cmd_valid4 = 1'b0;
        cmd4       = CMD_NOP;
        check("sat_edge0", cycle_count4, 0);
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat_edge%0d", j), cycle_count4, (j > 15) ? 15 : j);
        end
        check("sat_running", running4, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
